// File: rtl/rst_seq.sv
// rst_seq: staged reset sequencer fed by the PLL lock signal.
// The PLL `locked` output is the asynchronous reset. Its release is
// synchronised into clkin, the block waits for the clocks to settle, then
// releases the domain resets one at a time and finally raises `ready`.
// A soft-reset request re-runs the staged release without a PLL re-lock.
//
// Ports:
//   clkin      in   1       system clock (PLL output domain)
//   rst_n      in   1       async active-low reset, driven by PLL locked
//   soft_req   in   1       soft-reset request, level, synchronous to clkin
//   rst_out_n  out  NSTAGE  per-domain active-low resets, bit k = stage k
//   ready      out  1       every stage released, sequence complete
//   soft_cnt   out  8       accepted soft resets, saturates at 255
module rst_seq #(
  parameter int unsigned NSTAGE     = 3,
  parameter int unsigned STABLE_CYC = 16,
  parameter int unsigned STAGE_GAP  = 4,
  parameter int unsigned HOLD_CYC   = 8
) (
  input  logic              clkin,
  input  logic              rst_n,
  input  logic              soft_req,
  output logic [NSTAGE-1:0] rst_out_n,
  output logic              ready,
  output logic [7:0]        soft_cnt
);

  // Shared cycle counter is sized for the longest of the three waits.
  localparam int unsigned MAX_AB  = (STABLE_CYC > STAGE_GAP) ? STABLE_CYC : STAGE_GAP;
  localparam int unsigned MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);
  localparam int unsigned SW      = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

  // Each wait matches one edge early because the match edge itself performs
  // the transition; this makes a wait of N cycles take exactly N edges.
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);
  localparam logic [SW-1:0] STAGE_LAST  = SW'(NSTAGE - 1);
  localparam logic [7:0]    SOFT_MAX    = 8'hFF;

  // Elaboration-time parameter legality checks.
  if (NSTAGE < 1 || NSTAGE > 8) begin : g_bad_nstage
    $error("rst_seq: NSTAGE must be in 1..8");
  end
  if (STABLE_CYC < 1) begin : g_bad_stable
    $error("rst_seq: STABLE_CYC must be >= 1");
  end
  if (STAGE_GAP < 1) begin : g_bad_gap
    $error("rst_seq: STAGE_GAP must be >= 1");
  end
  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("rst_seq: HOLD_CYC must be >= 1");
  end

  typedef enum logic [2:0] {
    S_SYNC    = 3'd0,
    S_STABLE  = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_q;
  logic              sync_ok;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic [NSTAGE-1:0] rst_d;
  logic              ready_d;
  logic [7:0]        soft_cnt_d;

  // Release synchroniser: cleared asynchronously, shifts in ones after release.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign sync_ok = sync_q[1];

  // State register.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A soft request in RELEASE/RUN always wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SYNC: begin
        if (sync_ok) begin
          state_d = (STABLE_CYC == 1) ? S_RELEASE : S_STABLE;
        end
      end
      S_STABLE: begin
        if (cnt_q == STABLE_LAST) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (soft_req) begin
          state_d = S_HOLD;
        end else if (stage_q == STAGE_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (soft_req) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!soft_req && cnt_q == HOLD_LAST) begin
          state_d = S_RELEASE;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  // Next values for the counters and the registered outputs.
  always_comb begin
    cnt_d      = cnt_q;
    stage_d    = stage_q;
    rst_d      = rst_out_n;
    ready_d    = ready;
    soft_cnt_d = soft_cnt;
    case (state_q)
      S_SYNC: begin
        cnt_d   = '0;
        stage_d = '0;
        if (sync_ok) begin
          // A one-cycle stability wait completes on the edge sync_ok is seen.
          if (STABLE_CYC == 1) begin
            rst_d = NSTAGE'(1);
          end else begin
            cnt_d = CW'(1);
          end
        end
      end
      S_STABLE: begin
        if (cnt_q == STABLE_LAST) begin
          rst_d   = NSTAGE'(1);
          cnt_d   = '0;
          stage_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RELEASE: begin
        if (soft_req) begin
          rst_d   = '0;
          ready_d = 1'b0;
          cnt_d   = '0;
          stage_d = '0;
          if (soft_cnt != SOFT_MAX) begin
            soft_cnt_d = soft_cnt + 8'd1;
          end
        end else if (stage_q == STAGE_LAST) begin
          ready_d = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          // Released bits form a thermometer code, so shifting in a one
          // releases exactly the next stage.
          rst_d   = NSTAGE'({rst_out_n, 1'b1});
          stage_d = stage_q + SW'(1);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        if (soft_req) begin
          rst_d   = '0;
          ready_d = 1'b0;
          cnt_d   = '0;
          stage_d = '0;
          if (soft_cnt != SOFT_MAX) begin
            soft_cnt_d = soft_cnt + 8'd1;
          end
        end
      end
      S_HOLD: begin
        // A request still high restarts the hold window without counting.
        if (soft_req) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          rst_d   = NSTAGE'(1);
          cnt_d   = '0;
          stage_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        rst_d   = '0;
        ready_d = 1'b0;
        cnt_d   = '0;
        stage_d = '0;
      end
    endcase
  end

  // Datapath and output registers; every output comes straight from a flop.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      stage_q   <= '0;
      rst_out_n <= '0;
      ready     <= 1'b0;
      soft_cnt  <= 8'd0;
    end else begin
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      rst_out_n <= rst_d;
      ready     <= ready_d;
      soft_cnt  <= soft_cnt_d;
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: default build plus an NSTAGE=1 build sharing
// the clock and the PLL-lock reset.
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       soft_req;
  logic       soft_req1;
  logic [2:0] rst_out_n;
  logic       ready;
  logic [7:0] soft_cnt;
  logic [0:0] rst_out1_n;
  logic       ready1;
  logic [7:0] soft_cnt1;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  rst_seq dut (
    .clkin    (clk),
    .rst_n    (rst_n),
    .soft_req (soft_req),
    .rst_out_n(rst_out_n),
    .ready    (ready),
    .soft_cnt (soft_cnt)
  );

  rst_seq #(.NSTAGE(1)) dut1 (
    .clkin    (clk),
    .rst_n    (rst_n),
    .soft_req (soft_req1),
    .rst_out_n(rst_out1_n),
    .ready    (ready1),
    .soft_cnt (soft_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset held for 5 cycles, released mid-cycle, then the 18/22/26/27
  // release timing is checked edge by edge. A soft pulse during STABLE
  // (edge 10) must be ignored.
  task automatic powerup();
    logic [2:0] er;
    rst_n    = 1'b0;
    soft_req = 1'b0;
    repeat (5) tick();
    check("rst_out_n_in_reset", rst_out_n, 3'b000);
    check("ready_in_reset", ready, 1'b0);
    check("soft_cnt_in_reset", soft_cnt, 8'd0);
    check("n1_rst_in_reset", rst_out1_n, 1'b0);
    check("n1_ready_in_reset", ready1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 27; e++) begin
      soft_req = (e == 10);
      tick();
      er = (e >= 26) ? 3'b111 : (e >= 22) ? 3'b011 : (e >= 18) ? 3'b001 : 3'b000;
      check($sformatf("pwr_rst_e%0d", e), rst_out_n, er);
      check($sformatf("pwr_ready_e%0d", e), ready, (e >= 27) ? 1'b1 : 1'b0);
      check($sformatf("n1_rst_e%0d", e), rst_out1_n, (e >= 18) ? 1'b1 : 1'b0);
      check($sformatf("n1_ready_e%0d", e), ready1, (e >= 19) ? 1'b1 : 1'b0);
    end
    soft_req = 1'b0;
    check("pwr_soft_cnt", soft_cnt, 8'd0);
  endtask

  // From the edge that last sampled soft_req high: bit0 +8, bit1 +12,
  // bit2 +16, ready +17.
  task automatic run_release(input string tag);
    logic [2:0] er;
    for (int k = 1; k <= 17; k++) begin
      tick();
      er = (k >= 16) ? 3'b111 : (k >= 12) ? 3'b011 : (k >= 8) ? 3'b001 : 3'b000;
      check($sformatf("%s_rst_k%0d", tag, k), rst_out_n, er);
      check($sformatf("%s_ready_k%0d", tag, k), ready, (k >= 17) ? 1'b1 : 1'b0);
    end
  endtask

  // Single-edge soft request; the next edge must drop everything.
  task automatic pulse_soft(input string tag);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    exp_cnt++;
    check({tag, "_rst"}, rst_out_n, 3'b000);
    check({tag, "_ready"}, ready, 1'b0);
    check({tag, "_cnt"}, soft_cnt, exp_cnt);
  endtask

  // Drop lock between edges; outputs must clear with no clock edge.
  task automatic lock_loss(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_rst"}, rst_out_n, 3'b000);
    check({tag, "_ready"}, ready, 1'b0);
    check({tag, "_cnt"}, soft_cnt, 8'd0);
    check({tag, "_n1_rst"}, rst_out1_n, 1'b0);
    check({tag, "_n1_ready"}, ready1, 1'b0);
    exp_cnt = 0;
  endtask

  initial begin
    rst_n     = 1'b0;
    soft_req  = 1'b0;
    soft_req1 = 1'b0;

    powerup();

    // Soft reset from RUN.
    pulse_soft("soft_run");
    run_release("soft_run");

    // Stretched request: 5 high samples count as one soft reset.
    soft_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stretch_rst_%0d", i), rst_out_n, 3'b000);
    end
    soft_req = 1'b0;
    exp_cnt++;
    check("stretch_cnt", soft_cnt, exp_cnt);
    run_release("stretch");

    // Soft request one edge after bit 0 rises restarts the hold.
    pulse_soft("pre_rel");
    repeat (7) tick();
    check("pre_rel_bit0_low", rst_out_n, 3'b000);
    tick();
    check("pre_rel_bit0", rst_out_n, 3'b001);
    pulse_soft("in_rel");
    run_release("in_rel");

    // Lock loss during RELEASE with two stages out of reset.
    pulse_soft("ll_rel_soft");
    repeat (12) tick();
    check("ll_rel_pre", rst_out_n, 3'b011);
    lock_loss("ll_rel");
    powerup();

    // Lock loss during HOLD.
    pulse_soft("ll_hold_soft");
    repeat (3) tick();
    check("ll_hold_pre", rst_out_n, 3'b000);
    lock_loss("ll_hold");
    powerup();

    // 260 soft resets, each re-issued as soon as bit 0 is back up.
    for (int i = 0; i < 260; i++) begin
      soft_req = 1'b1;
      tick();
      soft_req = 1'b0;
      repeat (8) tick();
      if (i == 254) check("sat_cnt_255th", soft_cnt, 8'd255);
    end
    check("sat_cnt_final", soft_cnt, 8'd255);
    check("sat_rst_bit0", rst_out_n, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Consumer end of the PLL lock/reset interface: takes the PLL `locked` output as its asynchronous active-low reset.
- Synchronises the reset release into the `clkin` domain and waits for the clocks to be stable.
- Releases a set of staged domain resets in order (e.g. SDRAM ctrl, video, CPU), then signals `ready`.
- Supports a synchronous soft-reset request that re-runs the staged release without needing a PLL re-lock.

Parameters:
- NSTAGE, 3, number of staged reset outputs (1..8).
- STABLE_CYC, 16, cycles waited after the synchronised release before stage 0 (>=1).
- STAGE_GAP, 4, cycles between consecutive stage releases (>=1).
- HOLD_CYC, 8, minimum soft-reset assertion length in cycles (>=1).

Ports:
- clkin  in  1  system clock (PLL output domain).
- rst_n  in  1  reset; driven by PLL locked; 0 = reset.
- soft_req  in  1  soft-reset request, synchronous to clkin, level.
- rst_out_n  out  NSTAGE  per-domain reset, active-low; bit k is stage k.
- ready  out  1  all stages released, sequence complete.
- soft_cnt  out  8  count of accepted soft resets, saturating at 255.

Behaviour:
- One clock; reset is asynchronous and active-low: `rst_n` low asserts immediately with no clock needed.
  - During reset: rst_out_n = 0 (all bits), ready = 0, soft_cnt = 0, FSM = SYNC, all counters = 0.
- Release synchroniser:
  - 2-flop chain, async-cleared by rst_n, D = 1.
  - Output sync_ok goes high on the 2nd rising edge after rst_n deasserts between edges.
- FSM states: SYNC, STABLE, RELEASE, RUN, HOLD.
  - SYNC: wait for sync_ok. On the edge sync_ok is first seen high → STABLE, cnt = 1.
  - STABLE: cnt increments each edge. When cnt == STABLE_CYC → drive rst_out_n[0] = 1, enter RELEASE, stage = 0, cnt = 0.
  - RELEASE: cnt increments. When cnt == STAGE_GAP → set bit stage+1, stage++, cnt = 0. After the last bit is set → next edge sets ready = 1, enter RUN.
  - RUN: outputs stable, waits for soft_req.
  - HOLD: cnt counts HOLD_CYC edges. soft_req high in HOLD resets cnt to 0 (request stretching). At HOLD_CYC → rst_out_n[0] = 1, enter RELEASE; no STABLE wait.
- Resulting release timing, defaults, edges counted from the rst_n release:
  - rst_out_n[0] at edge 2+STABLE_CYC = 18.
  - bit 1 at 22, bit 2 at 26.
  - ready at 27.
- NSTAGE = 1: ready rises one edge after bit 0.
- Soft reset:
  - soft_req is sampled in RELEASE or RUN. On the edge it is sampled high: rst_out_n = 0, ready = 0, cnt = 0, enter HOLD.
  - soft_cnt increments by 1 on that edge, saturating at 255.
  - Stretch restarts inside HOLD do not increment soft_cnt.
  - soft_req is ignored in SYNC and STABLE.
  - soft_req held continuously keeps the block in HOLD indefinitely.
- rst_out_n bits only ever rise in index order and all fall together. No output glitches: every output is driven by a flop.
- rst_n low at any point (mid-STABLE, mid-RELEASE, HOLD, RUN) aborts immediately: all outputs 0, FSM = SYNC, full sequence including STABLE on re-release.
- Counters are sized `$clog2(max(STABLE_CYC, STAGE_GAP, HOLD_CYC)+1)`. No wrap: each count is compared for equality and cleared on match.
- Illegal parameter values: elaboration error via generate-time check.

Test Plan:
- Power-up, defaults: rst_n low 5 cycles, then released mid-cycle. Required response:
  - rst_out_n = 3'b000 through edge 17; 3'b001 at 18, 3'b011 at 22, 3'b111 at 26.
  - ready = 1 at 27; soft_cnt = 0.
- Soft reset in RUN: 1-cycle soft_req pulse. Required response:
  - Next edge: rst_out_n = 0, ready = 0, soft_cnt = 1.
  - Bit 0 rises 8 edges later, bit 1 at +12, bit 2 at +16, ready at +17.
- Soft-request stretching: soft_req high for 5 cycles from RUN.
  - Bit 0 releases 8 edges after the last high sample; soft_cnt = 1 (not 5).
- Soft request in RELEASE: soft_req pulsed 1 edge after bit 0 rises.
  - All bits drop, soft_cnt increments, and the HOLD/RELEASE sequence restarts.
  - soft_req pulsed during STABLE → no effect.
- Lock loss: rst_n pulled low during RELEASE (rst_out_n = 3'b011) between edges.
  - Outputs go to 0 without a clock edge; re-release repeats the 18/22/26/27 timing.
  - Repeat with rst_n pulled low during HOLD.
- Saturation and NSTAGE = 1:
  - 260 soft resets → soft_cnt = 255.
  - Separate build with NSTAGE = 1: ready rises at edge 19 after power-up.
